// File: rtl/rob_commit_pkg.sv
// Shared types for the retire stage: commit FSM states and the per-slot ROB head view.
`ifndef XLEN
`define XLEN 32
`endif

package prv664_commit_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } commit_state_e;

   typedef struct packed {
      logic              valid;
      logic              complete;
      logic              exception;
      logic              csren;
      logic [4:0]        opcode;
      logic [`XLEN-1:0]  pc;
   } rob_head_t;

endpackage

// File: rtl/rob_commit_if.sv
// ROB-head inputs, pop acknowledges and the registered commit/CSR stream of the retire stage.
`ifndef XLEN
`define XLEN 32
`endif

interface rob_commit_if #(
   parameter int XLEN = `XLEN
);
   logic            head0_valid,     head1_valid;
   logic            head0_complete,  head1_complete;
   logic            head0_exception, head1_exception;
   logic            head0_csren,     head1_csren;
   logic [4:0]      head0_opcode,    head1_opcode;
   logic [XLEN-1:0] head0_pc,        head1_pc;
   logic [11:0]     head0_csrindex;
   logic [XLEN-1:0] head0_csrdata;
   logic            halt_i;

   logic            pop0_o, pop1_o;
   logic            instr0_commit_valid,  instr1_commit_valid;
   logic [4:0]      instr0_commit_opcode, instr1_commit_opcode;
   logic [XLEN-1:0] instr0_commit_pc,     instr1_commit_pc;
   logic            valid;
   logic            csren;
   logic [11:0]     csrindex;
   logic [XLEN-1:0] csrdata;
   logic            flush_o;
   logic            trap_o;
   logic [XLEN-1:0] trap_pc_o;

   // The commit unit drives the pops and the commit stream.
   modport master (
      input  head0_valid, head1_valid, head0_complete, head1_complete,
             head0_exception, head1_exception, head0_csren, head1_csren,
             head0_opcode, head1_opcode, head0_pc, head1_pc,
             head0_csrindex, head0_csrdata, halt_i,
      output pop0_o, pop1_o,
             instr0_commit_valid, instr1_commit_valid,
             instr0_commit_opcode, instr1_commit_opcode,
             instr0_commit_pc, instr1_commit_pc,
             valid, csren, csrindex, csrdata, flush_o, trap_o, trap_pc_o
   );

   modport slave (
      output head0_valid, head1_valid, head0_complete, head1_complete,
             head0_exception, head1_exception, head0_csren, head1_csren,
             head0_opcode, head1_opcode, head0_pc, head1_pc,
             head0_csrindex, head0_csrdata, halt_i,
      input  pop0_o, pop1_o,
             instr0_commit_valid, instr1_commit_valid,
             instr0_commit_opcode, instr1_commit_opcode,
             instr0_commit_pc, instr1_commit_pc,
             valid, csren, csrindex, csrdata, flush_o, trap_o, trap_pc_o
   );
endinterface

// File: rtl/rob_commit.sv
// Retire stage: pops up to two ROB heads per cycle and registers the commit/CSR stream,
// serialising CSR writes and traps behind a fixed-length flush window.
`ifndef XLEN
`define XLEN 32
`endif

module rob_commit
   import prv664_commit_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int XLEN         = `XLEN
) (
   input  logic         clk_i,
   input  logic         arst_i,
   rob_commit_if.master rob
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   commit_state_e   state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   rob_head_t       h0, h1;
   logic            pop0, pop1;
   logic            retire0, csr_retire, trap_retire;

   logic            v0_q, v1_q, valid_q, csren_q, flush_q, trap_q;
   logic [4:0]      op0_q, op1_q;
   logic [XLEN-1:0] pc0_q, pc1_q, csrdata_q, trap_pc_q;
   logic [11:0]     csrindex_q;

   assign h0 = '{valid:     rob.head0_valid,
                 complete:  rob.head0_complete,
                 exception: rob.head0_exception,
                 csren:     rob.head0_csren,
                 opcode:    rob.head0_opcode,
                 pc:        rob.head0_pc};
   assign h1 = '{valid:     rob.head1_valid,
                 complete:  rob.head1_complete,
                 exception: rob.head1_exception,
                 csren:     rob.head1_csren,
                 opcode:    rob.head1_opcode,
                 pc:        rob.head1_pc};

   // Slot 1 only retires alongside an ordinary slot 0; CSR writes and traps go alone from slot 0.
   always_comb begin
      pop0        = (state_q == RUN) && !rob.halt_i && h0.valid && h0.complete;
      pop1        = pop0 && h1.valid && h1.complete &&
                    !h0.exception && !h0.csren && !h1.exception && !h1.csren;
      trap_retire = pop0 && h0.exception;
      csr_retire  = pop0 && h0.csren && !h0.exception;
      retire0     = pop0 && !h0.exception;
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (arst_i) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (rob.halt_i) begin
               state_d = HALT;
            end else if (trap_retire || csr_retire) begin
               state_d = FLUSH;
               cnt_d   = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            // The flush window always runs to completion before a pending halt is honoured.
            if (cnt_q == 4'd0) state_d = rob.halt_i ? HALT : RUN;
            else               cnt_d   = cnt_q - 4'd1;
         end
         HALT: begin
            if (!rob.halt_i) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         v0_q       <= 1'b0;
         v1_q       <= 1'b0;
         valid_q    <= 1'b0;
         csren_q    <= 1'b0;
         flush_q    <= 1'b0;
         trap_q     <= 1'b0;
         op0_q      <= '0;
         op1_q      <= '0;
         pc0_q      <= '0;
         pc1_q      <= '0;
         csrindex_q <= '0;
         csrdata_q  <= '0;
         trap_pc_q  <= '0;
      end else begin
         v0_q    <= retire0;
         v1_q    <= pop1;
         valid_q <= retire0;
         csren_q <= csr_retire;
         flush_q <= trap_retire || csr_retire;
         trap_q  <= trap_retire;
         // Payload registers only load with their strobe and otherwise hold.
         if (retire0) begin
            op0_q <= h0.opcode;
            pc0_q <= h0.pc;
         end
         if (pop1) begin
            op1_q <= h1.opcode;
            pc1_q <= h1.pc;
         end
         if (csr_retire) begin
            csrindex_q <= rob.head0_csrindex;
            csrdata_q  <= rob.head0_csrdata;
         end
         if (trap_retire) trap_pc_q <= h0.pc;
      end
   end

   assign rob.pop0_o               = pop0;
   assign rob.pop1_o               = pop1;
   assign rob.instr0_commit_valid  = v0_q;
   assign rob.instr1_commit_valid  = v1_q;
   assign rob.instr0_commit_opcode = op0_q;
   assign rob.instr1_commit_opcode = op1_q;
   assign rob.instr0_commit_pc     = pc0_q;
   assign rob.instr1_commit_pc     = pc1_q;
   assign rob.valid                = valid_q;
   assign rob.csren                = csren_q;
   assign rob.csrindex             = csrindex_q;
   assign rob.csrdata              = csrdata_q;
   assign rob.flush_o              = flush_q;
   assign rob.trap_o               = trap_q;
   assign rob.trap_pc_o            = trap_pc_q;

endmodule

// File: tb/tb_rob_commit.sv
// Directed scoreboard bench for rob_commit: stimulus queues cycle-stamped expectations,
// a monitor checks the registered commit stream every cycle.
`ifndef XLEN
`define XLEN 32
`endif

module tb_rob_commit;

   localparam int         XLEN   = `XLEN;
   localparam logic [4:0] OP_ALU = 5'h0C;
   localparam logic [4:0] OP_SYS = 5'h1C;

   typedef struct {
      int              cyc;
      bit              v0, v1, csr, flush, trap;
      logic [4:0]      op0, op1;
      logic [XLEN-1:0] pc0, pc1, dat, tpc;
      logic [11:0]     idx;
   } exp_t;

   logic clk = 1'b0;
   logic arst;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];

   rob_commit_if #(.XLEN(XLEN)) rob_if ();

   rob_commit #(.FLUSH_CYCLES(2), .XLEN(XLEN)) dut (
      .clk_i  (clk),
      .arst_i (arst),
      .rob    (rob_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_h0(input bit v, c, e, s, input logic [4:0] op, input logic [XLEN-1:0] pc,
                         input logic [11:0] idx, input logic [XLEN-1:0] dat);
      rob_if.head0_valid     = v;
      rob_if.head0_complete  = c;
      rob_if.head0_exception = e;
      rob_if.head0_csren     = s;
      rob_if.head0_opcode    = op;
      rob_if.head0_pc        = pc;
      rob_if.head0_csrindex  = idx;
      rob_if.head0_csrdata   = dat;
   endtask

   task automatic set_h1(input bit v, c, e, s, input logic [4:0] op, input logic [XLEN-1:0] pc);
      rob_if.head1_valid     = v;
      rob_if.head1_complete  = c;
      rob_if.head1_exception = e;
      rob_if.head1_csren     = s;
      rob_if.head1_opcode    = op;
      rob_if.head1_pc        = pc;
   endtask

   task automatic idle();
      set_h0(0, 0, 0, 0, '0, '0, '0, '0);
      set_h1(0, 0, 0, 0, '0, '0);
   endtask

   task automatic push(input bit v0, v1, input logic [4:0] op0, op1,
                       input logic [XLEN-1:0] pc0, pc1, input bit csr,
                       input logic [11:0] idx, input logic [XLEN-1:0] dat,
                       input bit flush, trap, input logic [XLEN-1:0] tpc);
      exp_t e;
      e.cyc = cyc + 1;
      e.v0 = v0;   e.v1 = v1;   e.op0 = op0; e.op1 = op1;
      e.pc0 = pc0; e.pc1 = pc1; e.csr = csr; e.idx = idx; e.dat = dat;
      e.flush = flush; e.trap = trap; e.tpc = tpc;
      exp_q.push_back(e);
   endtask

   task automatic exp_norm(input bit v1, input logic [XLEN-1:0] pc0, pc1);
      push(1, v1, OP_ALU, OP_ALU, pc0, pc1, 0, '0, '0, 0, 0, '0);
   endtask

   task automatic exp_csr(input logic [XLEN-1:0] pc0, input logic [11:0] idx, input logic [XLEN-1:0] dat);
      push(1, 0, OP_SYS, '0, pc0, '0, 1, idx, dat, 1, 0, '0);
   endtask

   task automatic exp_trap(input logic [XLEN-1:0] tpc);
      push(0, 0, '0, '0, '0, '0, 0, '0, '0, 1, 1, tpc);
   endtask

   // Called at a negedge after the heads are set: check the combinational pops, advance one cycle.
   task automatic step(input string name, input bit p0, input bit p1);
      #1;
      check({name, ".pop0"}, 64'(rob_if.pop0_o), 64'(p0));
      check({name, ".pop1"}, 64'(rob_if.pop1_o), 64'(p1));
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".strobes"}, 64'({rob_if.instr0_commit_valid, rob_if.instr1_commit_valid,
                                    rob_if.valid, rob_if.csren, rob_if.flush_o, rob_if.trap_o}), 64'd0);
      check({tag, ".trap_pc"},  64'(rob_if.trap_pc_o),        64'd0);
      check({tag, ".pc0"},      64'(rob_if.instr0_commit_pc), 64'd0);
      check({tag, ".csrindex"}, 64'(rob_if.csrindex),         64'd0);
      check({tag, ".csrdata"},  64'(rob_if.csrdata),          64'd0);
   endtask

   // Monitor: an entry stamped for this cycle is compared in full; any other cycle must be quiet.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("commit.v0",    64'(rob_if.instr0_commit_valid), 64'(e.v0));
            check("commit.v1",    64'(rob_if.instr1_commit_valid), 64'(e.v1));
            check("commit.valid", 64'(rob_if.valid),               64'(e.v0));
            check("commit.csren", 64'(rob_if.csren),               64'(e.csr));
            check("commit.flush", 64'(rob_if.flush_o),             64'(e.flush));
            check("commit.trap",  64'(rob_if.trap_o),              64'(e.trap));
            if (e.v0) begin
               check("commit.op0", 64'(rob_if.instr0_commit_opcode), 64'(e.op0));
               check("commit.pc0", 64'(rob_if.instr0_commit_pc),     64'(e.pc0));
            end
            if (e.v1) begin
               check("commit.op1", 64'(rob_if.instr1_commit_opcode), 64'(e.op1));
               check("commit.pc1", 64'(rob_if.instr1_commit_pc),     64'(e.pc1));
            end
            if (e.csr) begin
               check("commit.csrindex", 64'(rob_if.csrindex), 64'(e.idx));
               check("commit.csrdata",  64'(rob_if.csrdata),  64'(e.dat));
            end
            if (e.trap) check("commit.trap_pc", 64'(rob_if.trap_pc_o), 64'(e.tpc));
         end else begin
            check("idle.strobes", 64'({rob_if.instr0_commit_valid, rob_if.instr1_commit_valid,
                                       rob_if.valid, rob_if.csren, rob_if.flush_o, rob_if.trap_o}), 64'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rob_if.halt_i = 1'b0;
      arst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      arst = 1'b0;
      @(negedge clk);

      // Two ordinary entries retire together.
      set_h0(1, 1, 0, 0, OP_ALU, 'h1000, '0, '0);
      set_h1(1, 1, 0, 0, OP_ALU, 'h1004);
      exp_norm(1, 'h1000, 'h1004);
      step("pair", 1, 1);

      // CSR write at slot 0 retires alone, then two blocked FLUSH cycles.
      set_h0(1, 1, 0, 1, OP_SYS, 'h1008, 12'hB00, 'h55);
      set_h1(1, 1, 0, 0, OP_ALU, 'h100C);
      exp_csr('h1008, 12'hB00, 'h55);
      step("csr", 1, 0);
      set_h0(1, 1, 0, 0, OP_ALU, 'h100C, '0, '0);
      set_h1(0, 0, 0, 0, '0, '0);
      step("csr_flush1", 0, 0);
      step("csr_flush2", 0, 0);
      exp_norm(0, 'h100C, '0);
      step("csr_resume", 1, 0);

      // Exception at slot 0: trap pulse, no retire, FLUSH, then normal pair.
      set_h0(1, 1, 1, 0, OP_ALU, 'h2000, '0, '0);
      set_h1(1, 1, 0, 0, OP_ALU, 'h2004);
      exp_trap('h2000);
      step("exc", 1, 0);
      set_h0(1, 1, 0, 0, OP_ALU, 'h2004, '0, '0);
      set_h1(1, 1, 0, 0, OP_ALU, 'h2008);
      step("exc_flush1", 0, 0);
      step("exc_flush2", 0, 0);
      exp_norm(1, 'h2004, 'h2008);
      step("exc_resume", 1, 1);

      // CSR write in slot 1 waits until it reaches slot 0.
      set_h0(1, 1, 0, 0, OP_ALU, 'h3000, '0, '0);
      set_h1(1, 1, 0, 1, OP_SYS, 'h3004);
      exp_norm(0, 'h3000, '0);
      step("h1csr_slot0", 1, 0);
      set_h0(1, 1, 0, 1, OP_SYS, 'h3004, 12'h340, 'hAA);
      set_h1(1, 1, 0, 0, OP_ALU, 'h3008);
      exp_csr('h3004, 12'h340, 'hAA);
      step("h1csr_moved", 1, 0);
      set_h0(1, 1, 0, 0, OP_ALU, 'h3008, '0, '0);
      set_h1(0, 0, 0, 0, '0, '0);
      step("h1csr_flush1", 0, 0);
      step("h1csr_flush2", 0, 0);
      exp_norm(0, 'h3008, '0);
      step("h1csr_resume", 1, 0);

      // Exception in slot 1 never pairs.
      set_h0(1, 1, 0, 0, OP_ALU, 'h3010, '0, '0);
      set_h1(1, 1, 1, 0, OP_ALU, 'h3014);
      exp_norm(0, 'h3010, '0);
      step("h1exc", 1, 0);

      // Halt for three cycles, release, resume one cycle later.
      set_h0(1, 1, 0, 0, OP_ALU, 'h4000, '0, '0);
      set_h1(1, 1, 0, 0, OP_ALU, 'h4004);
      rob_if.halt_i = 1'b1;
      for (int i = 0; i < 3; i++) step("halt", 0, 0);
      rob_if.halt_i = 1'b0;
      step("halt_release", 0, 0);
      exp_norm(1, 'h4000, 'h4004);
      step("halt_resume", 1, 1);

      // Halt raised during FLUSH: window completes, then HALT until release.
      set_h0(1, 1, 0, 1, OP_SYS, 'h5000, 12'hB02, 'h7);
      set_h1(0, 0, 0, 0, '0, '0);
      exp_csr('h5000, 12'hB02, 'h7);
      step("hf_csr", 1, 0);
      set_h0(1, 1, 0, 0, OP_ALU, 'h5004, '0, '0);
      rob_if.halt_i = 1'b1;
      step("hf_flush1", 0, 0);
      step("hf_flush2", 0, 0);
      step("hf_halt", 0, 0);
      rob_if.halt_i = 1'b0;
      step("hf_release", 0, 0);
      exp_norm(0, 'h5004, '0);
      step("hf_resume", 1, 0);

      // Reset asserted mid-FLUSH clears the pulses and returns straight to RUN.
      set_h0(1, 1, 1, 0, OP_ALU, 'h6000, '0, '0);
      exp_trap('h6000);
      step("rst_exc", 1, 0);
      set_h0(1, 1, 0, 0, OP_ALU, 'h6004, '0, '0);
      arst = 1'b1;
      #1;
      check_all_zero("rst_mid_flush");
      @(negedge clk);
      arst = 1'b0;
      exp_norm(0, 'h6004, '0);
      step("rst_resume", 1, 0);

      // Incomplete head0 blocks a complete head1.
      set_h0(1, 0, 0, 0, OP_ALU, 'h7000, '0, '0);
      set_h1(1, 1, 0, 0, OP_ALU, 'h7004);
      step("in_order", 0, 0);

      idle();
      repeat (3) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
